pad_in_conditioner: RTL and testbench

//  Conditions the raw ui pad inputs (p2c of sg13g2_IOPadIn) before they reach the user core.
//  Per bit: synchronizer, optional debounce filter, rise/fall pulses. Whole vector: change

---
 rtl/pad_in_pkg.sv | 10 +
 rtl/pad_in_debounce_bit.sv | 77 +++++++
 rtl/pad_in_conditioner.sv | 88 ++++++++
 tb/tb_pad_in_conditioner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pad_in_pkg.sv
// Shared constants and types for the ui pad input conditioner.
package pad_in_pkg;

    localparam int UI_WIDTH        = 17;
    localparam int DB_CYCLES_DEF   = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef logic [UI_WIDTH-1:0] ui_vec_t;

endpackage : pad_in_pkg

// File: rtl/pad_in_debounce_bit.sv
// One conditioned pad bit: synchronizer chain, optional debounce counter,
// accepted level and registered rise/fall pulses. The next accepted level is
// exported so the parent can detect vector-wide changes one cycle early.
module pad_in_debounce_bit #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pad,
    input  logic i_db_en,
    output logic o_state,
    output logic o_next_state,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_state;
    logic                   r_rise;
    logic                   r_fall;

    logic                   w_sync;
    logic                   w_mismatch;
    logic                   w_next_state;
    logic [CNT_W-1:0]       w_next_cnt;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_mismatch = (w_sync != r_state);

    // Next accepted level and counter: bypass follows the synchronizer directly,
    // debounce only accepts a level that has disagreed for DB_CYCLES cycles.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch cannot be inferred.
        w_next_state = r_state;
        w_next_cnt   = '0;
        if (!i_db_en) begin
            w_next_state = w_sync;
        end else if (w_mismatch) begin
            if (r_cnt == CNT_LAST) begin
                w_next_state = w_sync;
            end else begin
                w_next_cnt = r_cnt + CNT_W'(1);
            end
        end
    end

    // Synchronizer, counter, state and edge pulses; all cleared by async reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_state <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pad};
            r_cnt   <= w_next_cnt;
            r_state <= w_next_state;
            r_rise  <= ~r_state & w_next_state;
            r_fall  <= r_state & ~w_next_state;
        end
    end

    assign o_state      = r_state;
    assign o_next_state = w_next_state;
    assign o_rise       = r_rise;
    assign o_fall       = r_fall;

endmodule : pad_in_debounce_bit

// File: rtl/pad_in_conditioner.sv
// Conditions the raw ui pad inputs for the user core: per-bit sync/debounce/
// edge pulses, plus a valid/ready snapshot channel with a sticky overflow flag.
module pad_in_conditioner
    import pad_in_pkg::*;
#(
    parameter int WIDTH       = UI_WIDTH,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] db_en_i,
    output logic [WIDTH-1:0] state_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [WIDTH-1:0] evt_data_o,
    output logic             evt_ovf_o,
    input  logic             evt_ovf_clr_i
);

    logic [WIDTH-1:0] w_state;
    logic [WIDTH-1:0] w_next_state;
    logic             w_chg;
    logic             w_drop;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_ovf;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        pad_in_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_bit (
            .i_clk       (clk_i),
            .i_rst       (rst_i),
            .i_pad       (pad_i[gi]),
            .i_db_en     (db_en_i[gi]),
            .o_state     (w_state[gi]),
            .o_next_state(w_next_state[gi]),
            .o_rise      (rise_o[gi]),
            .o_fall      (fall_o[gi])
        );
    end

    assign w_chg  = |(w_next_state ^ w_state);
    // A change arriving while a stalled snapshot is pending is lost.
    assign w_drop = r_valid & ~evt_ready_i & w_chg;

    // Snapshot channel: capture on change, hold while stalled, release on accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (!r_valid) begin
            if (w_chg) begin
                r_valid <= 1'b1;
                r_data  <= w_next_state;
            end
        end else if (evt_ready_i) begin
            if (w_chg) begin
                r_data <= w_next_state;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (evt_ovf_clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign state_o     = w_state;
    assign evt_valid_o = r_valid;
    assign evt_data_o  = r_data;
    assign evt_ovf_o   = r_ovf;

endmodule : pad_in_conditioner

// File: tb/tb_pad_in_conditioner.sv
// Directed bench for pad_in_conditioner (WIDTH=17, SYNC_STAGES=2, DB_CYCLES=8).
module tb_pad_in_conditioner;

    localparam int W = 17;
    localparam logic [W-1:0] ALL1 = 17'h1FFFF;

    logic         clk;
    logic         rst;
    logic [W-1:0] pad;
    logic [W-1:0] db_en;
    logic [W-1:0] state_w;
    logic [W-1:0] rise_w;
    logic [W-1:0] fall_w;
    logic         valid_w;
    logic         ready;
    logic [W-1:0] data_w;
    logic         ovf_w;
    logic         ovf_clr;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [W-1:0] pad;
        logic [W-1:0] state;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         valid;
        logic [W-1:0] data;
    } vec_t;

    vec_t vecs [7];

    pad_in_conditioner #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .DB_CYCLES  (8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pad_i        (pad),
        .db_en_i      (db_en),
        .state_o      (state_w),
        .rise_o       (rise_w),
        .fall_o       (fall_w),
        .evt_valid_o  (valid_w),
        .evt_ready_i  (ready),
        .evt_data_o   (data_w),
        .evt_ovf_o    (ovf_w),
        .evt_ovf_clr_i(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] st, input logic [W-1:0] ri,
                             input logic [W-1:0] fa, input logic va, input logic ov);
        check({tag, ".state"}, 32'(state_w), 32'(st));
        check({tag, ".rise"},  32'(rise_w),  32'(ri));
        check({tag, ".fall"},  32'(fall_w),  32'(fa));
        check({tag, ".valid"}, 32'(valid_w), 32'(va));
        check({tag, ".ovf"},   32'(ovf_w),   32'(ov));
    endtask

    initial begin
        logic [W-1:0] prev;
        n_cmp = 0;
        n_bad = 0;

        // Bypass-mode vectors, applied from state 17'h00008 with ready held high.
        vecs[0] = '{17'h00008, 17'h00008, 17'h00000, 17'h00000, 1'b0, 17'h00000};
        vecs[1] = '{17'h1F0F0, 17'h1F0F0, 17'h1F0F0, 17'h00008, 1'b1, 17'h1F0F0};
        vecs[2] = '{17'h00F0F, 17'h00F0F, 17'h00F0F, 17'h1F0F0, 1'b1, 17'h00F0F};
        vecs[3] = '{17'h1FFFF, 17'h1FFFF, 17'h1F0F0, 17'h00000, 1'b1, 17'h1FFFF};
        vecs[4] = '{17'h00000, 17'h00000, 17'h00000, 17'h1FFFF, 1'b1, 17'h00000};
        vecs[5] = '{17'h10001, 17'h10001, 17'h10001, 17'h00000, 1'b1, 17'h10001};
        vecs[6] = '{17'h10001, 17'h10001, 17'h00000, 17'h00000, 1'b0, 17'h00000};

        // 1 Reset with all pads high and debounce on everywhere.
        rst = 1'b1; pad = ALL1; db_en = ALL1; ready = 1'b0; ovf_clr = 1'b0;
        tick(3);
        check_all("rst", '0, '0, '0, 1'b0, 1'b0);
        check("rst.data", 32'(data_w), 32'h0);
        rst = 1'b0;
        tick(9);
        check("rel9.state", 32'(state_w), 32'h0);
        check("rel9.valid", 32'(valid_w), 32'h0);
        tick(1);
        check_all("rel10", ALL1, ALL1, '0, 1'b1, 1'b0);
        check("rel10.data", 32'(data_w), 32'(ALL1));
        tick(1);
        check_all("rel11", ALL1, '0, '0, 1'b1, 1'b0);
        ready = 1'b1;
        tick(1);
        check("accept.valid", 32'(valid_w), 32'h0);

        // 2 Debounced fall of everything, then glitch filtering on bit 3.
        pad = '0;
        tick(10);
        check_all("fall10", '0, '0, ALL1, 1'b1, 1'b0);
        check("fall10.data", 32'(data_w), 32'h0);
        tick(1);
        check("fall11.valid", 32'(valid_w), 32'h0);
        pad[3] = 1'b1;
        tick(7);
        pad[3] = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick(1);
            check_all($sformatf("glitch%0d", c), '0, '0, '0, 1'b0, 1'b0);
        end
        pad[3] = 1'b1;
        tick(9);
        check("b3.t9.state", 32'(state_w), 32'h0);
        tick(1);
        check_all("b3.t10", 17'h00008, 17'h00008, '0, 1'b1, 1'b0);
        tick(1);
        check_all("b3.t11", 17'h00008, '0, '0, 1'b0, 1'b0);

        // 3 Single-cycle pulse on a bypassed bit.
        db_en[0] = 1'b0;
        pad[0] = 1'b1;
        tick(1);
        pad[0] = 1'b0;
        tick(1);
        check("byp.t2.state", 32'(state_w), 32'h00008);
        tick(1);
        check_all("byp.t3", 17'h00009, 17'h00001, '0, 1'b1, 1'b0);
        check("byp.t3.data", 32'(data_w), 32'h00009);
        tick(1);
        check_all("byp.t4", 17'h00008, '0, 17'h00001, 1'b1, 1'b0);
        check("byp.t4.data", 32'(data_w), 32'h00008);
        tick(1);
        check_all("byp.t5", 17'h00008, '0, '0, 1'b0, 1'b0);

        // Table of bypass-mode vectors.
        db_en = '0;
        tick(2);
        check_all("byp.idle", 17'h00008, '0, '0, 1'b0, 1'b0);
        prev = 17'h00008;
        for (int v = 0; v < 7; v++) begin
            pad = vecs[v].pad;
            tick(2);
            check($sformatf("vec%0d.lat", v), 32'(state_w), 32'(prev));
            tick(1);
            check_all($sformatf("vec%0d", v), vecs[v].state, vecs[v].rise, vecs[v].fall,
                      vecs[v].valid, 1'b0);
            if (vecs[v].valid) begin
                check($sformatf("vec%0d.data", v), 32'(data_w), 32'(vecs[v].data));
            end
            prev = vecs[v].state;
        end

        // 4 Backpressure: second change is dropped and flagged.
        ready = 1'b0;
        pad = 17'h10021;
        tick(3);
        check("bp1.valid", 32'(valid_w), 32'h1);
        check("bp1.data",  32'(data_w),  32'h10021);
        check("bp1.ovf",   32'(ovf_w),   32'h0);
        pad = 17'h10061;
        tick(3);
        check("bp2.state", 32'(state_w), 32'h10061);
        check("bp2.valid", 32'(valid_w), 32'h1);
        check("bp2.data",  32'(data_w),  32'h10021);
        check("bp2.ovf",   32'(ovf_w),   32'h1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("bp3.valid", 32'(valid_w), 32'h0);
        check("bp3.ovf",   32'(ovf_w),   32'h1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("bp4.ovf", 32'(ovf_w), 32'h0);

        // 5 Accept and change in the same cycle; then clear losing to a drop.
        pad = 17'h10065;
        tick(3);
        check("sim1.valid", 32'(valid_w), 32'h1);
        check("sim1.data",  32'(data_w),  32'h10065);
        pad = 17'h10061;
        tick(2);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("sim2.valid", 32'(valid_w), 32'h1);
        check("sim2.data",  32'(data_w),  32'h10061);
        check("sim2.ovf",   32'(ovf_w),   32'h0);
        pad = 17'h10065;
        tick(2);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("sim3.state", 32'(state_w), 32'h10065);
        check("sim3.ovf",   32'(ovf_w),   32'h1);
        check("sim3.valid", 32'(valid_w), 32'h1);
        check("sim3.data",  32'(data_w),  32'h10061);

        // 6 Async reset in the middle of a debounce count on bit 7.
        db_en = ALL1;
        pad = 17'h100E5;
        tick(7);
        check_all("pre.rst", 17'h10065, '0, '0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all("async.rst", '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(9);
        check("rst6.t9.state", 32'(state_w), 32'h0);
        tick(1);
        check_all("rst6.t10", 17'h100E5, 17'h100E5, '0, 1'b1, 1'b0);
        check("rst6.t10.data", 32'(data_w), 32'h100E5);
        tick(1);
        check("rst6.t11.rise", 32'(rise_w), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pad_in_conditioner
